rd_serializer: RTL and testbench

RD_SERIALIZER -- requirements
Module: rd_serializer

---
 rtl/rd_serializer.sv | 112 +++++++++++
 tb/tb_rd_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_serializer.sv
// Serialises one interleaved frame read from memory port B, MSB first.
// Fetch, wait RD_LAT cycles, load the word, then shift it out under bit_ready backpressure.
module rd_serializer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned WORDS  = 512,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              Readclk,
  input  logic              reset,
  input  logic              frame_rdy,
  input  logic [DATA_W-1:0] doutb,
  input  logic              bit_ready,
  output logic              Enrd,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned CNT_W = (WORDS  > 1) ? $clog2(WORDS)  : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    word_q,  word_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;
  logic [LAT_W-1:0]    lat_q,   lat_d;
  logic [DATA_W-1:0]   sh_q,    sh_d;
  logic                enrd_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    lat_d   = lat_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (frame_rdy) begin
          word_d  = '0;
          bit_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        lat_d   = LAT_W'(1);
        state_d = WAIT;
      end
      // lat_q counts cycles since the FETCH cycle; doutb is valid in cycle FETCH+RD_LAT
      WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          sh_d    = doutb;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          sh_d = sh_q << 1;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d = '0;
            if (word_q == CNT_W'(WORDS - 1)) begin
              state_d = DONE;
            end else begin
              word_d  = word_q + 1'b1;
              state_d = FETCH;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Readclk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      lat_q   <= '0;
      sh_q    <= '0;
      enrd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      lat_q   <= lat_d;
      sh_q    <= sh_d;
      enrd_q  <= (state_d == FETCH);
    end
  end

  assign Enrd       = enrd_q;
  assign bit_out    = sh_q[DATA_W-1];
  assign bit_valid  = (state_q == SHIFT);
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rd_serializer.sv
// Scoreboard bench for rd_serializer: memory model returns word index[3:0] with a 2-cycle read latency.
module tb_rd_serializer;

  localparam int DATA_W = 4;
  localparam int WORDS  = 512;
  localparam int RD_LAT = 2;

  logic              Readclk = 1'b0;
  logic              reset;
  logic              frame_rdy;
  logic [DATA_W-1:0] doutb;
  logic              bit_ready;
  logic              Enrd;
  logic              bit_out;
  logic              bit_valid;
  logic              frame_done;
  logic              busy;

  rd_serializer #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS),
    .RD_LAT (RD_LAT)
  ) dut (
    .Readclk    (Readclk),
    .reset      (reset),
    .frame_rdy  (frame_rdy),
    .doutb      (doutb),
    .bit_ready  (bit_ready),
    .Enrd       (Enrd),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 Readclk = ~Readclk;

  // Address generator advances on Enrd; registered BRAM read gives data in cycle FETCH+2.
  int unsigned rd_cnt;
  int unsigned idx_q;
  always @(posedge Readclk) begin
    if (reset) begin
      rd_cnt <= 0;
      idx_q  <= 0;
      doutb  <= '0;
    end else begin
      if (Enrd) begin
        idx_q  <= rd_cnt;
        rd_cnt <= rd_cnt + 1;
      end
      doutb <= idx_q[3:0];
    end
  end

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   enrd_cnt = 0;
  int   done_cnt = 0;
  int   xfer_cnt = 0;
  int   first_enrd_cyc = -1;
  int   done_cyc = -1;
  logic sb[$];

  initial forever begin
    @(posedge Readclk);
    cyc++;
  end

  // Monitor: pops one expected bit per accepted transfer.
  initial begin : monitor
    logic e;
    forever begin
      @(negedge Readclk);
      if (!reset) begin
        if (bit_valid && bit_ready) begin
          xfer_cnt++;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_bit got=%0b expected=none (transfer %0d)", bit_out, xfer_cnt);
          end else begin
            e = sb.pop_front();
            if (bit_out !== e) begin
              fails++;
              $display("FAIL serial_bit transfer=%0d got=%0b expected=%0b", xfer_cnt, bit_out, e);
            end
          end
        end
        if (Enrd) begin
          if (enrd_cnt == 0) first_enrd_cyc = cyc;
          enrd_cnt++;
          tests++;
          if (bit_valid !== 1'b0) begin
            fails++;
            $display("FAIL enrd_while_valid got=%0b expected=0", bit_valid);
          end
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Readclk);
    #1;
  endtask

  task automatic start_frame();
    logic [3:0] d;
    enrd_cnt       = 0;
    done_cnt       = 0;
    xfer_cnt       = 0;
    first_enrd_cyc = -1;
    done_cyc       = -1;
    for (int w = 0; w < WORDS; w++) begin
      d = 4'(w);
      for (int b = DATA_W - 1; b >= 0; b--) sb.push_back(d[b]);
    end
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
    chk("fetch_entry_busy", busy, 1);
    chk("fetch_entry_enrd", Enrd, 1);
  endtask

  task automatic wait_xfers(input int n, input string name);
    int k;
    for (k = 0; k < 8000 && xfer_cnt < n; k++) tick();
    if (xfer_cnt < n) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout got=%0d expected=%0d", name, xfer_cnt, n);
    end
  endtask

  task automatic wait_done(output bit seen);
    int k;
    seen = 1'b0;
    for (k = 0; k < 5000 && !seen; k++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL frame_done_timeout got=0 expected=1");
    end
  endtask

  initial begin : stim
    bit seen;
    reset     = 1'b1;
    frame_rdy = 1'b1;
    bit_ready = 1'b1;

    repeat (3) begin
      tick();
      chk("reset_outputs", {Enrd, bit_valid, bit_out, frame_done, busy}, 0);
    end
    reset     = 1'b0;
    frame_rdy = 1'b0;
    tick();
    chk("idle_after_reset", {Enrd, busy, bit_valid}, 0);

    // Frame 1: clean timing, frame_rdy pulses mid-frame and in DONE ignored.
    start_frame();
    for (int k = 0; k < 3000 && enrd_cnt < 200; k++) tick();
    frame_rdy = 1'b1;
    tick();
    frame_rdy = 1'b0;
    wait_done(seen);
    if (seen) begin
      chk("done_busy", busy, 1);
      chk("done_valid", bit_valid, 0);
      frame_rdy = 1'b1;
      tick();
      frame_rdy = 1'b0;
      chk("done_one_cycle", frame_done, 0);
      chk("idle_after_done", busy, 0);
    end
    repeat (5) tick();
    chk("f1_still_idle", {busy, Enrd}, 0);
    chk("f1_enrd_count", enrd_cnt, WORDS);
    chk("f1_done_count", done_cnt, 1);
    chk("f1_done_cycle", done_cyc - first_enrd_cyc, WORDS * (1 + RD_LAT + DATA_W));
    chk("f1_sb_empty", sb.size(), 0);

    // Frame 2: reset in the middle of word 100.
    start_frame();
    wait_xfers(WORDS > 100 ? 401 : 1, "f2_word100");
    chk("f2_enrd_before_reset", enrd_cnt, 101);
    reset = 1'b1;
    tick();
    chk("midreset_outputs", {Enrd, bit_valid, bit_out, frame_done, busy}, 0);
    reset = 1'b0;
    sb.delete();
    tick();
    chk("midreset_idle", {Enrd, busy}, 0);

    // Frame 3: restarts at word 0; 10-cycle stall after the second bit of word 5.
    start_frame();
    wait_xfers(22, "f3_word5");
    bit_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Readclk);
      chk("bp_bit_out", bit_out, 0);
      chk("bp_bit_valid", bit_valid, 1);
      chk("bp_no_enrd", Enrd, 0);
    end
    tick();
    bit_ready = 1'b1;
    wait_done(seen);
    repeat (5) tick();
    chk("f3_enrd_count", enrd_cnt, WORDS);
    chk("f3_done_count", done_cnt, 1);
    chk("f3_done_cycle", done_cyc - first_enrd_cyc, WORDS * (1 + RD_LAT + DATA_W) + 10);
    chk("f3_xfer_count", xfer_cnt, WORDS * DATA_W);
    chk("f3_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
